// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Optional build macro IFU_BSWAP_EN selects byte-swapped instruction words.
package ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [XLEN-1:0] bswap32(input logic [XLEN-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: instruction memory request/response, core redirect and
// instruction handoff. master = fetch unit, slave = memory/core side.
interface ifu_if;
  import ifu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifu_fifo.sv
// In-order instruction buffer of fetch entries with flush; DEPTH is a power of 2.
module ifu_fifo import ifu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       head_valid,
  output logic [cnt_w(DEPTH)-1:0]    count
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_push    = push && !flush;
  assign do_pop     = pop && head_valid && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries data only; validity lives entirely in count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Credit logic upstream must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (!reset) !(do_push && !do_pop && count == FULL));
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: fetch PC, credit-limited imem requests, redirect flush.
// Define IFU_BSWAP_EN to byte-swap returned words (big-endian memory model).
module ifu_fetch import ifu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input logic  clk,
  input logic  reset,
  ifu_if.master bus
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic             req_fire;
  logic             rsp_keep;
  logic             pop;
  logic             head_valid;
  logic [XLEN-1:0]  rsp_inst;
  fetch_entry_t     rsp_entry;
  fetch_entry_t     head;
  logic             unused_redirect_lsb;

  // Every in-flight request plus every buffered word holds one buffer slot.
  assign bus.imem_req_valid = reset && !bus.redirect_valid &&
                              (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

`ifdef IFU_BSWAP_EN
  assign rsp_inst = bswap32(bus.imem_rsp_data);
`else
  assign rsp_inst = bus.imem_rsp_data;
`endif

  // Oldest live request sits 'outstanding' words behind fetch_pc once drops drain.
  assign rsp_entry = '{pc: fetch_pc - (XLEN'(outstanding) << 2), inst: rsp_inst};
  assign rsp_keep  = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop       = head_valid && bus.inst_ready;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding - CNT_W'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .push       (rsp_keep),
    .push_data  (rsp_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign bus.inst_valid = head_valid;
  assign bus.inst_pc    = head_valid ? head.pc   : '0;
  assign bus.inst       = head_valid ? head.inst : '0;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: queue-based reference model plus a latency-programmable memory.
module tb_ifu_fetch;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h8000_0000;
`ifdef IFU_BSWAP_EN
  localparam logic [31:0] EXP13 = 32'h1300_0000;
  localparam logic [31:0] EXP6  = 32'h0000_0013;
`else
  localparam logic [31:0] EXP13 = 32'h0000_0013;
  localparam logic [31:0] EXP6  = 32'h1300_0000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifu_if bus();
  ifu_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] pc; bit drop; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  infl_t m_inf[$];
  ent_t  m_out[$];
  mreq_t mem_q[$];
  logic [31:0] m_pc;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_delay = 0;
  int fire_cnt = 0;
  int deliver_cnt = 0;
  bit rand_mode = 0;
  bit use_const = 1;
  logic [31:0] mem_const = 32'h13;

  function automatic logic [31:0] xf(input logic [31:0] d);
`ifdef IFU_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] dfn(input logic [31:0] a);
    return use_const ? mem_const : ((a * 32'h0001_0003) ^ 32'h1357_9bdf);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit credit_ok();
    return !bus.redirect_valid && ((m_inf.size() + m_out.size()) < DEPTH);
  endfunction

  task automatic model_check();
    bit exp_rv;
    exp_rv = credit_ok();
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_out.size() > 0));
    if (m_out.size() > 0) begin
      chk("inst_pc", bus.inst_pc, m_out[0].pc);
      chk("inst", bus.inst, m_out[0].inst);
    end else begin
      chk("inst_pc_idle", bus.inst_pc, 32'h0);
      chk("inst_idle", bus.inst, 32'h0);
    end
  endtask

  // One clock: check at negedge, advance model and memory at posedge, drive at posedge+1.
  task automatic tick();
    logic r_v, rs_v, ir, fire;
    logic [31:0] r_pc, faddr;
    bit exp_fire, do_pop;
    infl_t e;
    mreq_t m;
    @(negedge clk);
    model_check();
    r_v = bus.redirect_valid;  r_pc = bus.redirect_pc;
    rs_v = bus.imem_rsp_valid; ir = bus.inst_ready;
    fire = bus.imem_req_valid && bus.imem_req_ready;
    faddr = bus.imem_req_addr;
    exp_fire = credit_ok() && bus.imem_req_ready;
    do_pop = ir && (m_out.size() > 0);
    if (fire) fire_cnt++;
    if (do_pop) deliver_cnt++;
    @(posedge clk);
    cyc++;
    if (r_v) begin
      if (rs_v && m_inf.size() > 0) void'(m_inf.pop_front());
      foreach (m_inf[i]) m_inf[i].drop = 1'b1;
      m_out.delete();
      m_pc = {r_pc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(m_out.pop_front());
      if (rs_v && m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (!e.drop) m_out.push_back('{e.pc, xf(bus.imem_rsp_data)});
      end
      if (exp_fire) begin
        m_inf.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (fire) mem_q.push_back('{faddr, cyc + (rand_mode ? int'($urandom_range(0, 3)) : mem_delay)});
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = dfn(m.addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom();
    end
    if (rand_mode) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.inst_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 31) == 0);
      bus.redirect_pc    = $urandom();
    end
  endtask

  // Leaves the bench at posedge+1 with reset released and the model cleared.
  task automatic do_reset();
    reset = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    mem_q.delete(); m_inf.delete(); m_out.delete();
    m_pc = RPC; fire_cnt = 0; deliver_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (!bus.inst_valid && n < 30) begin
      tick(); #2; n++;
    end
    chk({name, "_valid"}, 32'(bus.inst_valid), 32'h1);
    chk(name, bus.inst_pc, exp_pc);
  endtask

  task automatic stream_on();
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    // 1: first fetch and two-cycle request-to-instruction latency
    use_const = 1; mem_const = 32'h13; mem_delay = 0;
    do_reset(); stream_on(); #2;
    chk("t1_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t1_req_addr", bus.imem_req_addr, 32'h8000_0000);
    tick(); #2;
    chk("t1_valid_early", 32'(bus.inst_valid), 32'h0);
    chk("t1_req_addr2", bus.imem_req_addr, 32'h8000_0004);
    tick(); #2;
    chk("t1_valid", 32'(bus.inst_valid), 32'h1);
    chk("t1_pc0", bus.inst_pc, 32'h8000_0000);
    chk("t1_inst0", bus.inst, EXP13);
    tick(); #2;
    wait_valid("t1_pc1", 32'h8000_0004);

    // 2: stalled core, credit stops at DEPTH requests
    do_reset(); bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;
    repeat (10) tick();
    #2;
    chk("t2_fires", 32'(fire_cnt), 32'(DEPTH));
    chk("t2_req_low", 32'(bus.imem_req_valid), 32'h0);
    chk("t2_pc0", bus.inst_pc, 32'h8000_0000);
    bus.inst_ready = 1'b1;
    tick(); #2;
    chk("t2_pc1", bus.inst_pc, 32'h8000_0004);

    // 3: redirect with two requests in flight
    do_reset(); mem_delay = 3; stream_on();
    tick(); tick(); #2;
    chk("t3_outstanding", 32'(fire_cnt), 32'h2);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0102; #1;
    chk("t3_no_req", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b0; #2;
    chk("t3_addr", bus.imem_req_addr, 32'h8000_0100);
    wait_valid("t3_first", 32'h8000_0100);

    // 4: redirect coinciding with a pop and a stale response
    do_reset(); mem_delay = 0; stream_on(); #2;
    n = 0;
    while (!(bus.inst_valid && bus.imem_rsp_valid) && n < 20) begin
      tick(); #2; n++;
    end
    chk("t4_setup", 32'(bus.inst_valid && bus.imem_rsp_valid), 32'h1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h9000_0041;
    tick();
    bus.redirect_valid = 1'b0; #2;
    chk("t4_flushed", 32'(bus.inst_valid), 32'h0);
    wait_valid("t4_first", 32'h9000_0040);

    // 5: randomized handshakes, latencies and redirects
    use_const = 0; rand_mode = 1;
    do_reset(); stream_on();
    repeat (3000) tick();
    rand_mode = 0;
    chk("t5_progress", 32'(deliver_cnt > 200), 32'h1);

    // 6: byte order of the returned word
    use_const = 1; mem_const = 32'h1300_0000;
    do_reset(); stream_on(); #2;
    wait_valid("t6_pc", 32'h8000_0000);
    chk("t6_inst", bus.inst, EXP6);

    // 7: reset asserted mid-stream
    use_const = 0; rand_mode = 1;
    do_reset(); stream_on();
    repeat (25) tick();
    rand_mode = 0;
    #1 reset = 1'b0;
    #1;
    chk("t7_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("t7_inst", bus.inst, 32'h0);
    chk("t7_inst_pc", bus.inst_pc, 32'h0);
    chk("t7_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("t7_req_addr", bus.imem_req_addr, RPC);
    do_reset(); stream_on(); #2;
    chk("t7_restart_addr", bus.imem_req_addr, RPC);
    wait_valid("t7_restart_pc", RPC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
